// File: rtl/screen_entry_fetcher_pkg.sv
// screen_entry_fetcher_pkg: shared BG screen-entry types, FSM states and text-entry field positions.
package screen_entry_fetcher_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam int TILE_LSB  = 0;
  localparam int TILE_MSB  = 9;
  localparam int HFLIP_BIT = 10;
  localparam int VFLIP_BIT = 11;
  localparam int PAL_LSB   = 12;
  localparam int PAL_MSB   = 15;
  typedef struct packed {
    logic [9:0] tile;
    logic       hflip;
    logic       vflip;
    logic [3:0] palette;
  } screen_entry_t;
endpackage

// File: rtl/screen_entry_decoder.sv
// screen_entry_decoder: decodes a VRAM halfword into a text (16-bit) or rotation (8-bit) screen entry.
module screen_entry_decoder
  import screen_entry_fetcher_pkg::*;
(
  input  logic [15:0]   rdata,
  input  logic          rotate,
  input  logic          byte_sel,
  output screen_entry_t entry
);
  logic [7:0] b;
  always_comb begin
    b = byte_sel ? rdata[15:8] : rdata[7:0];
    entry.tile = rotate ? {2'b00, b} : rdata[TILE_MSB:TILE_LSB];
    entry.hflip = !rotate && rdata[HFLIP_BIT];
    entry.vflip = !rotate && rdata[VFLIP_BIT];
    entry.palette = rotate ? 4'h0 : rdata[PAL_MSB:PAL_LSB];
  end
endmodule

// File: rtl/screen_entry_fetcher.sv
// screen_entry_fetcher: fetches one screen-map entry through the VRAM arbiter and hands it downstream.
// Optional one-entry cache enabled by SCREEN_ENTRY_CACHE_EN.
module screen_entry_fetcher
  import screen_entry_fetcher_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int TILE_W = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_rotate,
  input  logic              cache_inv,
  output logic              vram_rd_en,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_gnt,
  input  logic              vram_rvalid,
  input  logic [15:0]       vram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TILE_W-1:0] out_tile_num,
  output logic              out_hflip,
  output logic              out_vflip,
  output logic [3:0]        out_palette
);
  state_t state, next;
  logic [ADDR_W-1:0] addr;
  logic rotate;
  logic [15:0] data;
  logic hit;
  screen_entry_t entry;

`ifdef SCREEN_ENTRY_CACHE_EN
  // data always holds the last completed read, so only the tag needs storing
  logic [ADDR_W-2:0] c_addr;
  logic c_valid;
  assign hit = c_valid && !cache_inv && c_addr == req_addr[ADDR_W-1:1];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      c_addr <= '0;
      c_valid <= 1'b0;
    end else if (cache_inv) begin
      c_valid <= 1'b0;
    end else if (state == WAIT && vram_rvalid) begin
      c_addr <= addr[ADDR_W-1:1];
      c_valid <= 1'b1;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = cache_inv;
  assign hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      addr <= '0;
      rotate <= 1'b0;
      data <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req_valid) begin
        addr <= req_addr;
        rotate <= req_rotate;
      end
      if (state == WAIT && vram_rvalid) data <= vram_rdata;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = req_valid ? (hit ? HOLD : REQ) : IDLE;
      REQ:     next = vram_gnt ? WAIT : REQ;
      WAIT:    next = vram_rvalid ? HOLD : WAIT;
      default: next = out_ready ? IDLE : HOLD;
    endcase
  end

  screen_entry_decoder u_dec (
    .rdata    (data),
    .rotate   (rotate),
    .byte_sel (addr[0]),
    .entry    (entry)
  );

  assign req_ready = state == IDLE;
  assign vram_rd_en = state == REQ;
  assign vram_addr = {addr[ADDR_W-1:1], 1'b0};
  assign out_valid = state == HOLD;
  assign out_tile_num = out_valid ? TILE_W'(entry.tile) : '0;
  assign out_hflip = out_valid && entry.hflip;
  assign out_vflip = out_valid && entry.vflip;
  assign out_palette = out_valid ? entry.palette : 4'h0;
endmodule

// File: tb/tb_screen_entry_fetcher.sv
// tb_screen_entry_fetcher: directed self-checking bench for screen_entry_fetcher.
module tb_screen_entry_fetcher;
  logic clock = 0, reset_n = 0, req_valid = 0, req_rotate = 0, cache_inv = 0;
  logic vram_gnt = 0, vram_rvalid = 0, out_ready = 0;
  logic [15:0] req_addr = 0, vram_rdata = 0;
  logic req_ready, vram_rd_en, out_valid, out_hflip, out_vflip;
  logic [15:0] vram_addr;
  logic [9:0] out_tile_num;
  logic [3:0] out_palette;
  int checks = 0, failures = 0;

  screen_entry_fetcher dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_rotate(req_rotate), .cache_inv(cache_inv),
    .vram_rd_en(vram_rd_en), .vram_addr(vram_addr), .vram_gnt(vram_gnt),
    .vram_rvalid(vram_rvalid), .vram_rdata(vram_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_tile_num(out_tile_num), .out_hflip(out_hflip),
    .out_vflip(out_vflip), .out_palette(out_palette)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic [15:0] a, input logic r);
    req_addr = a;
    req_rotate = r;
    req_valid = 1;
    tick;
    req_valid = 0;
  endtask

  task automatic grant(input int n);
    repeat (n - 1) tick;
    vram_gnt = 1;
    tick;
    vram_gnt = 0;
  endtask

  task automatic respond(input int m, input logic [15:0] d);
    repeat (m - 1) tick;
    vram_rvalid = 1;
    vram_rdata = d;
    tick;
    vram_rvalid = 0;
  endtask

  task automatic drain;
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (vram_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", vram_rd_en); end
    checks++; if (vram_addr !== 16'h0) begin failures++; $display("FAIL reset_vram_addr got=%h exp=0000", vram_addr); end
    checks++; if ({out_valid, out_tile_num, out_hflip, out_vflip, out_palette} !== 17'h0) begin failures++; $display("FAIL reset_outputs got=%b_%h_%b%b_%h exp=0", out_valid, out_tile_num, out_hflip, out_vflip, out_palette); end
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    tick;
  endtask

  task automatic test_text;
    accept(16'h0802, 0);
    checks++; if (vram_rd_en !== 1'b1) begin failures++; $display("FAIL text_rd_en got=%b exp=1", vram_rd_en); end
    checks++; if (vram_addr !== 16'h0802) begin failures++; $display("FAIL text_vram_addr got=%h exp=0802", vram_addr); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL text_req_ready got=%b exp=0", req_ready); end
    grant(1);
    checks++; if (vram_rd_en !== 1'b0) begin failures++; $display("FAIL text_rd_en_after_gnt got=%b exp=0", vram_rd_en); end
    tick;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL text_out_valid_early got=%b exp=0", out_valid); end
    vram_rvalid = 1;
    vram_rdata = 16'hA7FF;
    tick;
    vram_rvalid = 0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL text_out_valid_4cyc got=%b exp=1", out_valid); end
    checks++; if (out_tile_num !== 10'h3FF) begin failures++; $display("FAIL text_tile got=%h exp=3ff", out_tile_num); end
    checks++; if ({out_hflip, out_vflip} !== 2'b10) begin failures++; $display("FAIL text_flips got=%b%b exp=10", out_hflip, out_vflip); end
    checks++; if (out_palette !== 4'hA) begin failures++; $display("FAIL text_palette got=%h exp=a", out_palette); end
    drain;
    checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL text_release got=valid%b ready%b exp=valid0 ready1", out_valid, req_ready); end
  endtask

  task automatic test_rotation;
    accept(16'h4003, 1);
    checks++; if (vram_addr !== 16'h4002) begin failures++; $display("FAIL rot_vram_addr got=%h exp=4002", vram_addr); end
    grant(1);
    respond(2, 16'h5C21);
    checks++; if (out_tile_num !== 10'h05C) begin failures++; $display("FAIL rot_odd_tile got=%h exp=05c", out_tile_num); end
    checks++; if ({out_hflip, out_vflip, out_palette} !== 6'h0) begin failures++; $display("FAIL rot_odd_attr got=%b%b_%h exp=00_0", out_hflip, out_vflip, out_palette); end
    drain;
    cache_inv = 1;
    accept(16'h4002, 1);
    cache_inv = 0;
    checks++; if (vram_rd_en !== 1'b1) begin failures++; $display("FAIL rot_even_rd_en got=%b exp=1", vram_rd_en); end
    grant(1);
    respond(2, 16'h5C21);
    checks++; if (out_tile_num !== 10'h021) begin failures++; $display("FAIL rot_even_tile got=%h exp=021", out_tile_num); end
    drain;
  endtask

  task automatic test_stall;
    accept(16'h1234, 0);
    for (int i = 0; i < 7; i++) begin
      checks++; if (vram_rd_en !== 1'b1 || vram_addr !== 16'h1234 || req_ready !== 1'b0) begin failures++; $display("FAIL stall_cycle%0d got=rd%b addr%h ready%b exp=rd1 addr1234 ready0", i, vram_rd_en, vram_addr, req_ready); end
      if (i == 3) begin
        vram_rvalid = 1;
        vram_rdata = 16'hFFFF;
      end
      tick;
      vram_rvalid = 0;
    end
    checks++; if (out_valid !== 1'b0 || vram_rd_en !== 1'b1) begin failures++; $display("FAIL stall_spurious got=valid%b rd%b exp=valid0 rd1", out_valid, vram_rd_en); end
    grant(1);
    respond(2, 16'h3456);
    checks++; if (out_tile_num !== 10'h056 || out_palette !== 4'h3) begin failures++; $display("FAIL stall_data got=%h_%h exp=056_3", out_tile_num, out_palette); end
    checks++; if ({out_hflip, out_vflip} !== 2'b10) begin failures++; $display("FAIL stall_flips got=%b%b exp=10", out_hflip, out_vflip); end
    drain;
  endtask

  task automatic test_backpressure;
    accept(16'h2000, 0);
    grant(1);
    respond(2, 16'h1C05);
    req_addr = 16'h2222;
    req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_tile_num !== 10'h005 || {out_hflip, out_vflip} !== 2'b11 || out_palette !== 4'h1 || req_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=valid%b tile%h flips%b%b pal%h ready%b exp=valid1 tile005 flips11 pal1 ready0", i, out_valid, out_tile_num, out_hflip, out_vflip, out_palette, req_ready); end
      tick;
    end
    req_valid = 0;
    drain;
    checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1 || vram_rd_en !== 1'b0) begin failures++; $display("FAIL bp_release got=valid%b ready%b rd%b exp=valid0 ready1 rd0", out_valid, req_ready, vram_rd_en); end
    checks++; if (vram_addr !== 16'h2000) begin failures++; $display("FAIL bp_no_accept got=%h exp=2000", vram_addr); end
  endtask

  task automatic test_reset_mid_wait;
    accept(16'h3000, 0);
    grant(1);
    tick;
    reset_n = 0;
    #1;
    checks++; if (req_ready !== 1'b1 || vram_rd_en !== 1'b0 || vram_addr !== 16'h0) begin failures++; $display("FAIL rst_wait_ctl got=ready%b rd%b addr%h exp=ready1 rd0 addr0000", req_ready, vram_rd_en, vram_addr); end
    checks++; if ({out_valid, out_tile_num, out_hflip, out_vflip, out_palette} !== 17'h0) begin failures++; $display("FAIL rst_wait_out got=%b_%h exp=0", out_valid, out_tile_num); end
    @(posedge clock);
    #1 reset_n = 1;
    tick;
    vram_rvalid = 1;
    vram_rdata = 16'hFFFF;
    tick;
    vram_rvalid = 0;
    checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_late_rvalid got=valid%b ready%b exp=valid0 ready1", out_valid, req_ready); end
    accept(16'h3002, 0);
    grant(1);
    respond(2, 16'h0123);
    checks++; if (out_valid !== 1'b1 || out_tile_num !== 10'h123 || out_palette !== 4'h0) begin failures++; $display("FAIL rst_next_fetch got=valid%b tile%h pal%h exp=valid1 tile123 pal0", out_valid, out_tile_num, out_palette); end
    drain;
  endtask

  task automatic test_cache;
    accept(16'h0100, 1);
    grant(1);
    respond(2, 16'hBEEF);
    checks++; if (out_tile_num !== 10'h0EF) begin failures++; $display("FAIL cache_fill_tile got=%h exp=0ef", out_tile_num); end
    drain;
    accept(16'h0101, 1);
`ifdef SCREEN_ENTRY_CACHE_EN
    checks++; if (vram_rd_en !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL cache_hit got=rd%b valid%b exp=rd0 valid1", vram_rd_en, out_valid); end
    checks++; if (out_tile_num !== 10'h0BE) begin failures++; $display("FAIL cache_hit_tile got=%h exp=0be", out_tile_num); end
    drain;
    cache_inv = 1;
    tick;
    cache_inv = 0;
    accept(16'h0100, 1);
    checks++; if (vram_rd_en !== 1'b1) begin failures++; $display("FAIL cache_inv_refetch got=%b exp=1", vram_rd_en); end
    grant(1);
    respond(2, 16'hBEEF);
    checks++; if (out_tile_num !== 10'h0EF) begin failures++; $display("FAIL cache_refetch_tile got=%h exp=0ef", out_tile_num); end
`else
    checks++; if (vram_rd_en !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL nocache_refetch got=rd%b valid%b exp=rd1 valid0", vram_rd_en, out_valid); end
    grant(1);
    respond(2, 16'hBEEF);
    checks++; if (out_tile_num !== 10'h0BE) begin failures++; $display("FAIL nocache_tile got=%h exp=0be", out_tile_num); end
`endif
    drain;
  endtask

  initial begin
    test_reset;
    test_text;
    test_rotation;
    test_stall;
    test_backpressure;
    test_reset_mid_wait;
    test_cache;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/screen_entry_fetcher.md
Name: screen_entry_fetcher

Overview:
Consumer side of the background screen-lookup address path.
- Accepts a VRAM byte address for one screen-map entry, plus the text/rotation mode flag.
- Performs the VRAM read through the VRAM arbiter's request/grant/read-valid interface.
- Decodes the returned halfword into tile number, flip bits and palette bank.
- Hands the decoded entry to the tile-data fetch stage over a valid/ready handshake.
- Sits between the screen address generator and the tile pixel fetcher in each BG pipeline.

Parameters:
ADDR_W, 16, VRAM byte-address width
TILE_W, 10, decoded tile-number width

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request address valid
req_ready  out  1  fetcher can accept a request
req_addr  in  ADDR_W  VRAM byte address of the screen entry
req_rotate  in  1  1 = rotation/scaling BG (8-bit entry), 0 = text BG (16-bit entry)
cache_inv  in  1  invalidate cached entry (VRAM write or BG control change)
vram_rd_en  out  1  read request to arbiter
vram_addr  out  ADDR_W  halfword-aligned read address, bit 0 always 0
vram_gnt  in  1  arbiter accepted the read this cycle
vram_rvalid  in  1  vram_rdata valid
vram_rdata  in  16  read halfword
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts the entry
out_tile_num  out  TILE_W  tile index
out_hflip  out  1  horizontal flip
out_vflip  out  1  vertical flip
out_palette  out  4  palette bank

Behaviour:
Reset:
- Clock and reset: one clock, `clock`; reset is asynchronous and active-low, port `reset_n`.
- Reset state: FSM = IDLE; all outputs 0 except req_ready = 1; internal address/mode/data registers cleared.
- Reset asserted mid-operation aborts any outstanding read. Any later vram_rvalid is ignored until a new request reaches WAIT.

FSM states:
- IDLE: req_ready = 1. When req_valid is high, latch req_addr and req_rotate, then go to REQ.
- REQ: vram_rd_en = 1 and vram_addr = {addr[ADDR_W-1:1], 1'b0}, both held stable. When vram_gnt is sampled high, go to WAIT. rd_en deasserts the cycle after the grant.
- WAIT: on vram_rvalid, capture vram_rdata and go to HOLD. vram_rvalid is never expected in the grant cycle. vram_rvalid arriving outside WAIT is ignored.
- HOLD: out_valid = 1, outputs stable. When out_ready is high, go to IDLE; out_valid drops the next cycle.

Timing:
- With gnt the cycle after acceptance and rvalid 2 cycles after gnt, out_valid rises 4 cycles after req acceptance.
- No back-to-back overlap: req_ready is low in REQ, WAIT and HOLD.

Decode, text mode (rotate = 0):
- tile = d[9:0]; hflip = d[10]; vflip = d[11]; palette = d[15:12].

Decode, rotation mode (rotate = 1):
- byte = addr[0] ? d[15:8] : d[7:0].
- tile = {2'b0, byte}; flips = 0; palette = 0.

Other rules:
- cache_inv has no effect unless the cache feature is compiled in.

Optional Feature:
Macro SCREEN_ENTRY_CACHE_EN.
- With the macro: one-entry cache holding the last fetched halfword address and its data, plus a valid bit.
- Hit condition: in IDLE, a request whose addr[ADDR_W-1:1] matches the cached address while the valid bit is set.
- On a hit, skip REQ/WAIT and go straight to HOLD using the cached data, decoded with the new addr[0] and rotate. out_valid rises the cycle after acceptance.
- Each completed VRAM read fills the cache.
- cache_inv clears the valid bit. If cache_inv coincides with a request, the request is treated as a miss.
- Reset clears the valid bit.
- Without the macro: no cache; every request goes through REQ/WAIT; cache_inv is ignored.

Decomposition:
- Shared bg package: state enum (IDLE, REQ, WAIT, HOLD), screen_entry_t struct (tile, hflip, vflip, palette), and text-entry field bit-position constants.
- Sub-module screen_entry_decoder: combinational, inputs rdata/rotate/byte_sel, output screen_entry_t. Reused by the affine BG path.

Test Plan:
- Text fetch: req_addr 16'h0802, rotate 0; gnt after 1 cycle; rdata 16'hA7FF → tile 10'h3FF, hflip 1, vflip 0, palette 4'hA; out_valid exactly 4 cycles after acceptance.
- Rotation odd byte: req_addr 16'h4003, rotate 1; rdata 16'h5C21 → vram_addr 16'h4002, tile 10'h05C, flips 0, palette 0. Same data with addr 16'h4002 → tile 10'h021.
- Arbiter stall: gnt withheld 7 cycles → vram_rd_en and vram_addr stable throughout, req_ready 0. Spurious rvalid during REQ is ignored.
- Downstream backpressure: out_ready low for 5 cycles → outputs stable, no new request accepted, transfer completes on the first out_ready.
- Reset mid-WAIT: assert reset_n low → all outputs 0 and req_ready 1 immediately. A late rvalid after release is ignored; the next request completes normally.
- Cache (macro on): fetch 16'h0100 then 16'h0101 with rotate 1 → second request issues no vram_rd_en and out_valid rises 1 cycle after acceptance. After a cache_inv pulse, 16'h0100 refetches.
